// File: rtl/tag_layer_sched_if.sv
// tag_layer_sched_if: insert, search, result and layer-memory signals of the tag layer scheduler
interface tag_layer_sched_if #(parameter int N = 4);
  logic ins_a_valid, ins_b_valid, ins_a_ready, ins_b_ready;
  logic [N+3:0] ins_a_tag, ins_b_tag;
  logic srch_valid, srch_ready;
  logic [N+3:0] srch_tag;
  logic res_valid, res_ready, res_found;
  logic [N+3:0] res_tag;
  logic mem_ena;
  logic [N-1:0] mem_rd_addr, mem_wr_addr;
  logic [15:0] mem_rd_data, mem_wr_data;
  logic [15:0] ins_count;
  modport master (
    output ins_a_valid, ins_b_valid, ins_a_tag, ins_b_tag, srch_valid, srch_tag, res_ready, mem_rd_data,
    input ins_a_ready, ins_b_ready, srch_ready, res_valid, res_found, res_tag, mem_ena, mem_rd_addr,
          mem_wr_addr, mem_wr_data, ins_count
  );
  modport slave (
    input ins_a_valid, ins_b_valid, ins_a_tag, ins_b_tag, srch_valid, srch_tag, res_ready, mem_rd_data,
    output ins_a_ready, ins_b_ready, srch_ready, res_valid, res_found, res_tag, mem_ena, mem_rd_addr,
           mem_wr_addr, mem_wr_data, ins_count
  );
endinterface

// File: rtl/tag_layer_sched.sv
// tag_layer_sched: insert arbiter and find-next search sequencer for one bitmap layer memory
module tag_layer_sched #(parameter int N = 4) (
  input logic clk,
  input logic rst,
  tag_layer_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic rr, a_v, b_v, same, gnt_a, gnt_b, conflict, found_q;
  logic [N-1:0] node_a, node_b, node_q;
  logic [15:0] mask_a, mask_b, masked, count_q;
  logic [16:0] sum;
  logic [3:0] start_q, lo;
  logic [N+3:0] tag_q;
  assign node_a = bus.ins_a_tag[N+3:4];
  assign node_b = bus.ins_b_tag[N+3:4];
  assign mask_a = 16'd1 << bus.ins_a_tag[3:0];
  assign mask_b = 16'd1 << bus.ins_b_tag[3:0];
  assign a_v = bus.ins_a_valid & ~rst;
  assign b_v = bus.ins_b_valid & ~rst;
  assign same = node_a == node_b;
  // rr low favours A; same-node pairs merge into one OR-write
  assign gnt_a = a_v & (~b_v | same | ~rr);
  assign gnt_b = b_v & (~a_v | same | rr);
  assign conflict = a_v & b_v & ~same;
  assign bus.ins_a_ready = gnt_a;
  assign bus.ins_b_ready = gnt_b;
  assign bus.mem_wr_addr = gnt_a ? node_a : gnt_b ? node_b : '0;
  assign bus.mem_wr_data = (gnt_a ? mask_a : '0) | (gnt_b ? mask_b : '0);
  assign bus.srch_ready = (state == IDLE) & ~rst;
  assign bus.mem_ena = bus.srch_ready & bus.srch_valid;
  assign bus.mem_rd_addr = bus.mem_ena ? bus.srch_tag[N+3:4] : '0;
  assign bus.res_valid = state == RESP;
  assign bus.res_found = found_q;
  assign bus.res_tag = tag_q;
  assign bus.ins_count = count_q;
  assign masked = bus.mem_rd_data & (16'hFFFF << start_q);
  assign sum = {1'b0, count_q} + 17'(gnt_a) + 17'(gnt_b);
  always_comb begin
    lo = '0;
    for (int i = 15; i >= 0; i--) if (masked[i]) lo = 4'(i);
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.srch_valid) state_n = WAIT;
    if (state == WAIT) state_n = RESP;
    if (state == RESP && bus.res_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr <= 1'b0;
      found_q <= 1'b0;
      tag_q <= '0;
      count_q <= '0;
      start_q <= '0;
      node_q <= '0;
    end else begin
      state <= state_n;
      if (conflict) rr <= ~rr;
      count_q <= sum[16] ? 16'hFFFF : sum[15:0];
      if (bus.mem_ena) begin
        start_q <= bus.srch_tag[3:0];
        node_q <= bus.srch_tag[N+3:4];
      end
      if (state == WAIT) begin
        found_q <= |masked;
        tag_q <= |masked ? {node_q, lo} : '0;
      end
    end
  end
endmodule

// File: tb/tb_tag_layer_sched.sv
// tb_tag_layer_sched: scoreboard bench with a bypassing layer-memory model around tag_layer_sched
module tb_tag_layer_sched;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  logic [8:0] q[$];
  logic [15:0] mem [16];
  logic [15:0] rd = '0;
  tag_layer_sched_if #(.N(4)) bus ();
  tag_layer_sched #(.N(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rd_data = rd;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 16'h0001;
  end
  always @(posedge clk) begin
    if (bus.mem_ena) rd <= mem[bus.mem_rd_addr] | (bus.mem_rd_addr == bus.mem_wr_addr ? bus.mem_wr_data : 16'h0);
    mem[bus.mem_wr_addr] <= mem[bus.mem_wr_addr] | bus.mem_wr_data;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      if (q.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("res_found", bus.res_found, e[8]);
        chk("res_tag", bus.res_tag, e[7:0]);
      end
    end
  end
  task automatic ins_cycle(input logic av, input logic [7:0] at, input logic bv, input logic [7:0] bt,
                           input logic ra, input logic rb, input logic [3:0] addr, input logic [15:0] data);
    bus.ins_a_valid = av; bus.ins_a_tag = at;
    bus.ins_b_valid = bv; bus.ins_b_tag = bt;
    @(negedge clk);
    chk("ins_a_ready", bus.ins_a_ready, ra);
    chk("ins_b_ready", bus.ins_b_ready, rb);
    chk("wr_addr", bus.mem_wr_addr, addr);
    chk("wr_data", bus.mem_wr_data, data);
    @(posedge clk); #1;
  endtask
  task automatic wait_res();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) chk("res_timeout", q.size(), 0);
    q.delete();
  endtask
  task automatic do_search(input logic [7:0] t, input logic f, input logic [7:0] et);
    for (int i = 0; i < 20 && !bus.srch_ready; i++) begin @(posedge clk); #1; end
    bus.srch_valid = 1'b1; bus.srch_tag = t;
    q.push_back({f, et});
    @(posedge clk); #1;
    bus.srch_valid = 1'b0;
    wait_res();
  endtask
  initial begin
    bus.ins_a_valid = 1'b1; bus.ins_a_tag = 8'h11;
    bus.ins_b_valid = 1'b0; bus.ins_b_tag = '0;
    bus.srch_valid = 1'b1; bus.srch_tag = '0; bus.res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_a_ready", bus.ins_a_ready, 0);
    chk("rst_wr_data", bus.mem_wr_data, 0);
    chk("rst_srch_ready", bus.srch_ready, 0);
    chk("rst_mem_ena", bus.mem_ena, 0);
    @(posedge clk); @(negedge clk);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_count", bus.ins_count, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    @(posedge clk); #1;
    bus.ins_a_valid = 1'b0; bus.srch_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    bus.srch_valid = 1'b1; bus.srch_tag = 8'h00;
    q.push_back({1'b1, 8'h00});
    @(negedge clk);
    chk("acc_mem_ena", bus.mem_ena, 1);
    chk("acc_rd_addr", bus.mem_rd_addr, 0);
    @(posedge clk); #1;
    bus.srch_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_valid", bus.res_valid, 0);
    chk("lat_c1_mem_ena", bus.mem_ena, 0);
    @(negedge clk);
    chk("lat_c2_valid", bus.res_valid, 1);
    @(posedge clk); #1;
    wait_res();
    ins_cycle(1, 8'h35, 0, 0, 1, 0, 4'h3, 16'h0020);
    ins_cycle(0, 0, 0, 0, 0, 0, 4'h0, 16'h0000);
    chk("count_1", bus.ins_count, 1);
    do_search(8'h32, 1, 8'h35);
    do_search(8'h36, 0, 8'h00);
    do_search(8'h01, 0, 8'h00);
    do_search(8'h10, 0, 8'h00);
    ins_cycle(0, 0, 1, 8'hFF, 0, 1, 4'hF, 16'h8000);
    ins_cycle(0, 0, 0, 0, 0, 0, 4'h0, 16'h0000);
    do_search(8'hFF, 1, 8'hFF);
    do_search(8'hF0, 1, 8'hFF);
    do_search(8'h3F, 0, 8'h00);
    ins_cycle(1, 8'h41, 1, 8'h4C, 1, 1, 4'h4, 16'h1002);
    ins_cycle(0, 0, 0, 0, 0, 0, 4'h0, 16'h0000);
    chk("count_4", bus.ins_count, 4);
    do_search(8'h42, 1, 8'h4C);
    ins_cycle(1, 8'h10, 1, 8'h20, 1, 0, 4'h1, 16'h0001);
    ins_cycle(1, 8'h10, 1, 8'h20, 0, 1, 4'h2, 16'h0001);
    ins_cycle(0, 0, 0, 0, 0, 0, 4'h0, 16'h0000);
    chk("count_6", bus.ins_count, 6);
    do_search(8'h10, 1, 8'h10);
    do_search(8'h20, 1, 8'h20);
    bus.ins_a_valid = 1'b1; bus.ins_a_tag = 8'h57;
    bus.srch_valid = 1'b1; bus.srch_tag = 8'h50;
    q.push_back({1'b1, 8'h57});
    @(posedge clk); #1;
    bus.srch_valid = 1'b0; bus.ins_a_tag = 8'h53;
    @(posedge clk); #1;
    bus.ins_a_valid = 1'b0;
    wait_res();
    chk("count_8", bus.ins_count, 8);
    do_search(8'h50, 1, 8'h53);
    bus.res_ready = 1'b0;
    bus.srch_valid = 1'b1; bus.srch_tag = 8'h33;
    @(posedge clk); #1;
    bus.srch_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.res_valid; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_tag", bus.res_tag, 8'h35);
      chk("hold_srch_ready", bus.srch_ready, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_srch_ready", bus.srch_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_srch_ready_1", bus.srch_ready, 1);
    chk("abort_count", bus.ins_count, 0);
    @(posedge clk); #1;
    q.delete();
    bus.res_ready = 1'b1;
    do_search(8'h40, 1, 8'h41);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tag_layer_sched.md
# tag_layer_sched

Sequencer and arbiter in front of one multibit-tree bitmap layer memory in the tag-sort datapath. It shares the memory's single OR-write port between two insert requesters, merging same-node inserts into one write, and runs single-port find-next searches over the memory's registered read port. It drives the layer memory's enable, read address, write address and write mask, and owns all ordering between inserts and searches.

## Interface
- N, 4, node address width; tag width is N+4 (upper N bits = node, lower 4 bits = bit index)
- W, 16, bitmap word width; fixed at 16 (one bit per 4-bit index)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ins_a_valid / ins_b_valid  in  1  insert request, ports A and B
- ins_a_tag / ins_b_tag  in  N+4  tag to insert
- ins_a_ready / ins_b_ready  out  1  grant, combinational
- srch_valid  in  1  search request
- srch_tag  in  N+4  search start tag
- srch_ready  out  1  high only in IDLE
- res_valid  out  1  search result valid
- res_ready  in  1  result consumed
- res_found  out  1  a set bit at index ≥ start index exists in the node
- res_tag  out  N+4  {node, first set index}; 0 when not found
- mem_ena  out  1  layer memory read enable
- mem_rd_addr  out  N  read address
- mem_rd_data  in  W  registered read data, 1-cycle latency; includes same-cycle write bypass
- mem_wr_addr  out  N  write address
- mem_wr_data  out  W  OR-mask. The memory ORs it into the addressed word every cycle, so it must be 0 whenever no insert is granted.
- ins_count  out  16  saturating count of accepted insert handshakes

## Operation
- Insert decode: mask = 1 << tag[3:0]; node = tag[N+3:4].
- Arbitration (combinational, same cycle):
  - Only one valid: that port is granted.
  - Both valid, same node: both are granted; mem_wr_data = mask_a | mask_b.
  - Both valid, different nodes: the port named by round-robin pointer rr is granted; rr then flips to the other port.
  - rr resets to A and changes only on conflict grants.
- A granted insert is written in the grant cycle: mem_wr_addr = granted node, mem_wr_data = granted mask(s).
- When no insert is granted, mem_wr_data = 0 and mem_wr_addr = 0.
- Inserts are accepted in every FSM state; search does not block inserts.
- Search FSM:
  - IDLE: srch_ready=1. On srch_valid, latch start index and node, drive mem_rd_addr = node and mem_ena=1, go to WAIT.
  - WAIT: masked = mem_rd_data & (16'hFFFF << start index). Register res_found = |masked and res_tag = {node, lowest set index of masked}, or 0 if none. Go to RESP.
  - RESP: res_valid=1, outputs held stable. On res_ready, go to IDLE.
- mem_ena is 0 outside the IDLE accept cycle, so the memory holds its read data.
- Ordering rule: a search sees every insert granted in or before its accept cycle, via the memory bypass. Inserts granted in later cycles are not guaranteed to be visible.
- ins_count increments by the number of handshakes per cycle (0, 1 or 2) and saturates at 16'hFFFF.
- Layer memory contents are not reset by rst. They power up with node 0 = 16'h0001 and all other nodes = 0.

## Timing
- Reset values: FSM=IDLE, rr=A, res_valid=0, res_found=0, res_tag=0, ins_count=0, mem_ena=0, mem_rd_addr=0, mem_wr_addr=0, mem_wr_data=0.
- During rst: ins_a_ready = ins_b_ready = srch_ready = 0 and no write mask is driven.
- Insert latency: the word is updated at the end of the grant cycle.
- Search latency: accepted at cycle 0; res_valid asserts at cycle 2.
- Search throughput: minimum 3 cycles per search with res_ready held high. srch_ready returns in the cycle after the res handshake.
- Reset mid-search aborts it: the FSM returns to IDLE and no result is produced.
- Boundaries:
  - Start index 15 examines only bit 15.
  - Start index 0 examines the whole word.
  - Node address N'h(2^N-1) is handled like any other node, with no wrap to node 0.
  - Search never crosses a node boundary.

## Test plan
- After reset, search tag 8'h00 → res_found=1, res_tag=8'h00 at cycle 2 (power-up bit).
- Insert A tag 8'h35, then search 8'h32 → res_found=1, res_tag=8'h35. Search 8'h36 → res_found=0, res_tag=0.
- A=8'h41 and B=8'h4C in the same cycle → both ready, mem_wr_addr=4, mem_wr_data=16'h1002, ins_count +2.
- A=8'h10 and B=8'h20 held valid for 2 cycles:
  - Cycle 0: A granted, mem_wr_data=16'h0001.
  - Cycle 1: B granted, mem_wr_data=16'h0001 at addr 2.
  - No cycle has both readies high.
- Insert 8'h57 in the same cycle as search 8'h50 is accepted → res_tag=8'h57. Insert 8'h53 in the WAIT cycle → the result is still 8'h57.
- res_ready held low 5 cycles → res_valid and res_tag stable, srch_ready=0. Assert rst mid-RESP → res_valid=0 next cycle and srch_ready=1 after rst deasserts.
